// File: rtl/fft_frame_packetizer.sv
// Overlapping-frame packetizer: buffers a sample stream in a 2*FRAME_LEN circular RAM
// and replays FRAME_LEN-word packets (sop/eop framed) every HOP_LEN samples toward an FFT sink.
module fft_frame_packetizer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 8192,
    parameter int HOP_LEN   = 8192
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sink_valid,
    input  logic              sink_ready,
    output logic [DATA_W-1:0] sink_data,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [15:0]       frames_sent,
    output logic [15:0]       overrun_cnt
);

    localparam int AW    = $clog2(FRAME_LEN) + 1;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 2 * FRAME_LEN;

    localparam logic [LW-1:0] L_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] L_FRAME = LW'(FRAME_LEN);
    localparam logic [LW-1:0] L_HOP   = LW'(HOP_LEN);
    localparam logic [LW-1:0] L_ONE   = LW'(1);
    localparam logic [AW-1:0] A_HOP   = AW'(HOP_LEN);
    localparam logic [AW-1:0] A_FRAME = AW'(FRAME_LEN);
    localparam logic [AW-1:0] A_LAST  = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] A_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] A_ONE   = AW'(1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SEND = 2'd1,
        ST_ADV  = 2'd2
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_ram_q;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_base_ptr;
    logic [AW-1:0]     r_rd_cnt;
    logic [LW-1:0]     r_level;
    logic              r_in_ready;
    logic              r_pf_valid;
    logic              r_pf_sop;
    logic              r_pf_eop;
    logic              r_sink_valid;
    logic [DATA_W-1:0] r_sink_data;
    logic              r_sink_sop;
    logic              r_sink_eop;
    logic [15:0]       r_frames;
    logic [15:0]       r_overrun;
    state_t            r_state;

    logic              w_accept;
    logic              w_advance;
    logic              w_out_fire;
    logic              w_out_free;
    logic              w_move;
    logic              w_rd_en;
    logic [AW-1:0]     w_rd_addr;
    logic [LW-1:0]     w_level_nxt;

    assign w_accept   = in_valid & r_in_ready;
    assign w_advance  = (r_state == ST_ADV);
    assign w_out_fire = r_sink_valid & sink_ready;
    assign w_out_free = ~r_sink_valid | sink_ready;
    assign w_move     = r_pf_valid & w_out_free;
    // A read is issued only when the prefetch register is guaranteed free next cycle.
    assign w_rd_en    = (r_state == ST_SEND) & (r_rd_cnt != A_FRAME) & (~r_pf_valid | w_move);
    assign w_rd_addr  = r_base_ptr + r_rd_cnt;

    // Next fill level: a write and a hop release may coincide.
    always_comb begin
        w_level_nxt = r_level;
        if (w_accept && w_advance) begin
            w_level_nxt = r_level + L_ONE - L_HOP;
        end else if (w_accept) begin
            w_level_nxt = r_level + L_ONE;
        end else if (w_advance) begin
            w_level_nxt = r_level - L_HOP;
        end else begin
            w_level_nxt = r_level;
        end
    end

    // Sample RAM: write port plus synchronous read into the prefetch register (no reset).
    always_ff @(posedge CLOCK_50) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= in_data;
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[w_rd_addr];
        end
    end

    // Write side: pointer, fill level, ready flag and saturating overrun counter.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= A_ZERO;
            r_level    <= {LW{1'b0}};
            r_in_ready <= 1'b1;
            r_overrun  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + A_ONE;
            end
            r_level    <= w_level_nxt;
            r_in_ready <= (w_level_nxt < L_FULL);
            if (in_valid && !r_in_ready && (r_overrun != 16'hFFFF)) begin
                r_overrun <= r_overrun + 16'd1;
            end
        end
    end

    // Frame FSM with prefetch stage and registered sink interface.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_FILL;
            r_base_ptr   <= A_ZERO;
            r_rd_cnt     <= A_ZERO;
            r_frames     <= 16'd0;
            r_pf_valid   <= 1'b0;
            r_pf_sop     <= 1'b0;
            r_pf_eop     <= 1'b0;
            r_sink_valid <= 1'b0;
            r_sink_data  <= {DATA_W{1'b0}};
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    r_rd_cnt <= A_ZERO;
                    if (r_level >= L_FRAME) begin
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_rd_en) begin
                        r_rd_cnt <= r_rd_cnt + A_ONE;
                    end
                    if (w_out_fire && r_sink_eop) begin
                        r_state <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    r_base_ptr <= r_base_ptr + A_HOP;
                    r_frames   <= r_frames + 16'd1;
                    r_rd_cnt   <= A_ZERO;
                    r_state    <= ST_FILL;
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase

            if (w_rd_en) begin
                r_pf_valid <= 1'b1;
                r_pf_sop   <= (r_rd_cnt == A_ZERO);
                r_pf_eop   <= (r_rd_cnt == A_LAST);
            end else if (w_move) begin
                r_pf_valid <= 1'b0;
            end

            if (w_move) begin
                r_sink_valid <= 1'b1;
                r_sink_data  <= r_ram_q;
                r_sink_sop   <= r_pf_sop;
                r_sink_eop   <= r_pf_eop;
            end else if (w_out_fire) begin
                r_sink_valid <= 1'b0;
                r_sink_sop   <= 1'b0;
                r_sink_eop   <= 1'b0;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign sink_valid  = r_sink_valid;
    assign sink_data   = r_sink_data;
    assign sink_sop    = r_sink_sop;
    assign sink_eop    = r_sink_eop;
    assign frames_sent = r_frames;
    assign overrun_cnt = r_overrun;

endmodule

// File: doc/fft_frame_packetizer.md
FFT_FRAME_PACKETIZER -- requirements
Module: fft_frame_packetizer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width in bits, 8..32.
REQ-002 SHALL have parameter FRAME_LEN, default 8192: samples per packet, power of two, 16..8192.
REQ-003 SHALL have parameter HOP_LEN, default 8192: samples between frame starts, power of two, 1..FRAME_LEN; HOP_LEN=FRAME_LEN means no overlap.
REQ-004 SHALL have port CLOCK_50, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: sample offered.
REQ-007 SHALL have port in_data, input, DATA_W: signed sample.
REQ-008 SHALL have port in_ready, output, 1: sample accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port sink_valid, output, 1: output word valid.
REQ-010 SHALL have port sink_ready, input, 1: FFT accepts the word when sink_valid and sink_ready are both high.
REQ-011 SHALL have port sink_data, output, DATA_W: output sample.
REQ-012 SHALL have port sink_sop, output, 1: first word of a frame.
REQ-013 SHALL have port sink_eop, output, 1: last word of a frame.
REQ-014 SHALL have port frames_sent, output, 16: count of completed packets; wraps.
REQ-015 SHALL have port overrun_cnt, output, 16: count of cycles with in_valid high and in_ready low; saturates at 0xFFFF.

Function
REQ-016 SHALL store samples in a circular RAM of depth 2*FRAME_LEN, with a synchronous one-cycle read.
REQ-017 SHALL keep wr_ptr and base_ptr, both wrapping modulo 2*FRAME_LEN; level = wr_ptr - base_ptr, width log2(FRAME_LEN)+2.
REQ-018 SHALL drive in_ready = (level < 2*FRAME_LEN); an accepted sample is written at wr_ptr and wr_ptr increments.
REQ-019 SHALL implement the state FILL: leave to SEND when level >= FRAME_LEN; sink_valid is low in FILL.
REQ-020 SHALL implement the state SEND: emit FRAME_LEN words read from base_ptr, base_ptr+1, and so on, in order.
REQ-021 SHALL implement the state ADVANCE: lasts one cycle; base_ptr += HOP_LEN; frames_sent += 1; go to FILL.
REQ-022 SHALL register sink_data, sink_valid, sink_sop and sink_eop, using a prefetch stage so that sink_valid stays high for consecutive words while sink_ready stays high: one word per cycle, no bubbles inside a packet after the first word.
REQ-023 SHALL set the first sink_valid of a packet no later than 2 cycles after entry to SEND.
REQ-024 SHALL hold sink_data, sink_sop and sink_eop stable while sink_valid is high and sink_ready is low.
REQ-025 SHALL assert sink_sop only on word 0 and sink_eop only on word FRAME_LEN-1, each together with sink_valid.
REQ-026 SHALL set ADVANCE on the cycle after the eop transfer completes.
REQ-027 SHALL, on a write in the same cycle as ADVANCE, update level by +1-HOP_LEN; no sample is lost or duplicated.
REQ-028 SHALL continue input acceptance during SEND; writes never overwrite addresses base_ptr..base_ptr+FRAME_LEN-1 of the current frame, because level is bounded.
REQ-029 SHALL, with HOP_LEN<FRAME_LEN, start consecutive frames HOP_LEN samples apart, so frame k+1 word 0 equals frame k word HOP_LEN.
REQ-030 SHALL not accept input when in_valid is high with level = 2*FRAME_LEN; overrun_cnt increments that cycle.

Reset
REQ-031 SHALL, while resetn is low, set: state FILL; wr_ptr = base_ptr = 0; in_ready 1 after release; sink_valid, sink_sop and sink_eop 0; sink_data 0; frames_sent 0; overrun_cnt 0.
REQ-032 SHALL abort a packet on reset mid-packet with no eop; the first packet after release starts with sink_sop on sample 0 written after release.
REQ-033 SHALL not have RAM contents reset; RAM contents are never output before being written after reset.

Verification (FRAME_LEN=16, HOP_LEN=8, DATA_W=16 unless noted)
REQ-034 SHALL verify non-overlap: with HOP_LEN=16, write samples 0..31 and hold sink_ready=1 -> two packets of 16 words, data 0..15 then 16..31, sop/eop on the correct words, frames_sent=2.
REQ-035 SHALL verify overlap: write samples 0..31 -> packets 0..15, 8..23, 16..31; frames_sent=3.
REQ-036 SHALL verify backpressure: toggle sink_ready pseudo-randomly -> data stable while stalled, no word lost or duplicated, exactly one sop and one eop per packet.
REQ-037 SHALL verify full: hold sink_ready=0 and offer 40 samples -> in_ready drops after 32 accepted; overrun_cnt=8; after release the packets continue correctly.
REQ-038 SHALL verify reset mid-packet: assert resetn=0 at word 5 -> sink_valid=0 immediately; the next packet starts with sop on new sample 0.
REQ-039 SHALL verify simultaneous events: a write on the ADVANCE cycle -> level correct, and the next packet content matches the reference model.
